// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_bram_array.sv
// Single-port, synchronous-read, write-first word array shaped for BRAM inference.
module dmem_bram_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DMEM_WORD_W-1:0] wd,
  output logic [DMEM_WORD_W-1:0] q
);

  logic [DMEM_WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write-first: a store also presents the new word on q.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wd;
        q         <= wd;
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the DataMemory slave handshake over an inferred BRAM.
// Optional feature: define DMEM_RANGE_CHECK_EN to drop/zero out-of-range accesses and raise a sticky err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        stall,
  output logic [31:0] rd,
  output logic        err,
  output logic [1:0]  fsm_state
);

  // Handshake: a request is offered while en=1; while stall=1 the master holds
  // en/we/addr/wd stable. A store completes in its cycle; a load completes in the
  // first cycle with stall=0 after acceptance, where rd carries the loaded word.

  localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(READ_LATENCY - 1);

  dmem_state_t            state, state_next;
  logic [DMEM_CNT_W-1:0]  cnt, cnt_next;
  logic                   stall_c;
  logic [DMEM_WORD_W-1:0] rd_hold, arr_q, load_data;
  logic                   oor, oor_q, accept, arr_en;
  logic                   addr_unused;

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;
  assign oor = (addr >> (ADDR_W + 2)) != 32'd0;
  assign err = err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if (accept && oor) begin
      err_q <= 1'b1;
    end
  end
`else
  assign oor = 1'b0;
  assign err = 1'b0;
`endif

  assign addr_unused = ^{addr[1:0], (addr >> (ADDR_W + 2))};

  assign accept = (state == IDLE) && en;
  assign arr_en = accept && !(we && oor);

  dmem_bram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (we),
    .addr (addr[ADDR_W+1:2]),
    .wd   (wd),
    .q    (arr_q)
  );

  // The array read register holds the word through the stall; rd_hold keeps it afterwards.
  assign load_data = oor_q ? '0 : arr_q;
  assign rd        = (state == DONE) ? load_data : rd_hold;
  assign stall     = stall_c && nrst;
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_c    = 1'b0;
    case (state)
      IDLE: begin
        if (en && !we) begin
          stall_c    = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = (READ_LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall_c  = 1'b1;
        cnt_next = cnt - 1'b1;
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == 1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_hold <= '0;
      oor_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept && !we) oor_q <= oor;
      if (state == DONE) rd_hold <= load_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, corner sequences and a randomized run against a word-array model.
module tb_dmem_responder;

  logic        clk;
  logic        nrst;
  logic        en_s   [2];
  logic        we_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic        stall_s[2];
  logic [31:0] rd_s   [2];
  logic        err_s  [2];
  logic [1:0]  st_s   [2];

  int checks = 0;
  int errors = 0;

  localparam int LAT [2] = '{2, 1};
  localparam int AW  [2] = '{16, 4};

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_rd [2];
  bit          ref_err [2];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  // dut_a: default geometry, two-cycle loads; dut_b: 16-word array, single-cycle loads
  dmem_responder #(.ADDR_W(16), .READ_LATENCY(2)) dut_a (
    .clk(clk), .nrst(nrst), .en(en_s[0]), .we(we_s[0]), .addr(addr_s[0]), .wd(wd_s[0]),
    .stall(stall_s[0]), .rd(rd_s[0]), .err(err_s[0]), .fsm_state(st_s[0])
  );

  dmem_responder #(.ADDR_W(4), .READ_LATENCY(1)) dut_b (
    .clk(clk), .nrst(nrst), .en(en_s[1]), .we(we_s[1]), .addr(addr_s[1]), .wd(wd_s[1]),
    .stall(stall_s[1]), .rd(rd_s[1]), .err(err_s[1]), .fsm_state(st_s[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit ref_oor(int k, logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return (a / (32'd4 << AW[k])) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned ref_key(int k, logic [31:0] a);
    int unsigned word;
    word = (a / 4) % (32'd1 << AW[k]);
    return (k << 20) | word;
  endfunction

  function automatic logic [31:0] ref_load(int k, logic [31:0] a);
    if (ref_oor(k, a)) return 32'h0;
    if (ref_mem.exists(ref_key(k, a))) return ref_mem[ref_key(k, a)];
    return 'x;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  // ---------------- drivers (called just after a rising edge) ----------------
  task automatic store(int k, logic [31:0] a, logic [31:0] d);
    en_s[k] = 1'b1; we_s[k] = 1'b1; addr_s[k] = a; wd_s[k] = d;
    if (ref_oor(k, a)) ref_err[k] = 1'b1;
    else ref_mem[ref_key(k, a)] = d;
    @(negedge clk);
    chk("store_stall", 32'(stall_s[k]), 32'd0);
    @(posedge clk); #1;
    en_s[k] = 1'b0; we_s[k] = 1'b0;
  endtask

  task automatic load(int k, logic [31:0] a, logic [31:0] exp);
    en_s[k] = 1'b1; we_s[k] = 1'b0; addr_s[k] = a;
    if (ref_oor(k, a)) ref_err[k] = 1'b1;
    for (int i = 0; i < LAT[k]; i++) begin
      @(negedge clk);
      chk("load_stall", 32'(stall_s[k]), 32'd1);
      chk("load_rd_hold", rd_s[k], last_rd[k]);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("load_done_stall", 32'(stall_s[k]), 32'd0);
    chk("load_rd", rd_s[k], exp);
    chk("load_err", 32'(err_s[k]), 32'(ref_err[k]));
    last_rd[k] = exp;
    @(posedge clk); #1;
    en_s[k] = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_rd[k] = 32'h0;
      ref_err[k] = 1'b0;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] a, d;

    vecs[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0040, 32'h1111_1111, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0044, 32'h2222_2222, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0043, 32'h0,         32'h1111_1111};
    vecs[5] = '{1'b0, 32'h0000_0044, 32'h0,         32'h2222_2222};
    vecs[6] = '{1'b1, 32'h0001_0000, 32'hAAAA_5555, 32'h0};
    vecs[7] = '{1'b0, 32'h0001_0000, 32'h0,         32'hAAAA_5555};

    nrst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wd_s[k] = '0;
    end
    model_reset();

    // reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_stall", 32'(stall_s[k]), 32'd0);
      chk("reset_rd", rd_s[k], 32'h0);
      chk("reset_err", 32'(err_s[k]), 32'd0);
    end
    chk("reset_state", 32'(st_s[0]), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    idle_cycle();

    // directed table on dut_a, applied back to back
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].we) store(0, vecs[i].addr, vecs[i].wd);
      else            load(0, vecs[i].addr, vecs[i].exp);
    end

    // single-cycle latency: back-to-back loads give stall 1,0,1,0
    store(1, 32'h0, 32'h0000_000A);
    store(1, 32'h4, 32'h0000_000B);
    load(1, 32'h0, 32'h0000_000A);
    load(1, 32'h4, 32'h0000_000B);

    // load abandoned in WAIT: rd keeps its previous value
    en_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h0000_0040;
    @(negedge clk);
    chk("abandon_accept_stall", 32'(stall_s[0]), 32'd1);
    @(posedge clk); #1;
    en_s[0] = 1'b0;
    @(negedge clk);
    chk("abandon_wait_stall", 32'(stall_s[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abandon_idle_stall", 32'(stall_s[0]), 32'd0);
    chk("abandon_rd", rd_s[0], last_rd[0]);
    @(posedge clk); #1;

    // reset during WAIT: stall drops at once, rd clears, next load is normal
    en_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h0000_0040;
    @(negedge clk);
    chk("midreset_accept_stall", 32'(stall_s[0]), 32'd1);
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    chk("midreset_stall", 32'(stall_s[0]), 32'd0);
    chk("midreset_rd", rd_s[0], 32'h0);
    en_s[0] = 1'b0;
    model_reset();
    @(posedge clk); #1;
    nrst = 1'b1;
    idle_cycle();
    load(0, 32'h0000_0044, 32'h2222_2222);

    // range check on the 16-word instance
    store(1, 32'h0000_0100, 32'h0000_0005);
`ifdef DMEM_RANGE_CHECK_EN
    load(1, 32'h0000_0100, 32'h0000_0000);
    chk("range_err", 32'(err_s[1]), 32'd1);
`else
    load(1, 32'h0000_0100, 32'h0000_0005);
    chk("range_err", 32'(err_s[1]), 32'd0);
`endif

    // randomized traffic on both instances against the model
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) begin
        a = (k == 0) ? (32'h2000 + 32'(w) * 4) : 32'(w) * 4;
        store(k, a, $urandom);
      end
      for (int n = 0; n < 60; n++) begin
        a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        if (k == 0) a = a + 32'h2000;
        else if ($urandom_range(0, 3) == 0) a = a | 32'h0000_0100;
        if ($urandom_range(0, 1) == 1) begin
          d = $urandom;
          store(k, a, d);
        end else begin
          exp_q.push_back(ref_load(k, a));
          load(k, a, exp_q.pop_front());
        end
        if ($urandom_range(0, 4) == 0) idle_cycle();
      end
    end

    @(negedge clk);
    chk("final_err_a", 32'(err_s[0]), 32'(ref_err[0]));
    chk("final_err_b", 32'(err_s[1]), 32'(ref_err[1]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Slave-side responder for the `DataMemory` handshake, backed by an inferred block-RAM word array. It accepts load/store requests from the core's memory stage. Stores complete in a single cycle. Loads hold `stall` high for a fixed, parameterised number of cycles and then present `rd`. The block sits between the core's data-memory master port and on-chip BRAM, and replaces the testbench behavioural memory.

## Interface
- `ADDR_W`, 16: word-address width; depth is 2^ADDR_W 32-bit words.
- `READ_LATENCY`, 2: cycles from load acceptance to data-valid cycle; legal range 1..15.
- `clk`  in  1: single clock, rising edge.
- `nrst`  in  1: asynchronous, active-low reset.
- `en`  in  1: request valid (slave modport input).
- `we`  in  1: 1 = store, 0 = load.
- `addr`  in  32: byte address; bits [1:0] ignored, word index = addr[ADDR_W+1:2].
- `wd`  in  32: store data.
- `stall`  out  1: master must hold `en`, `we`, `addr`, `wd` stable while high.
- `rd`  out  32: load data.
- `err`  out  1: sticky out-of-range flag; see Configuration.

## Operation
- FSM states:
  - IDLE.
  - WAIT: load outstanding, counter running.
  - DONE: load data valid.
- IDLE:
  - `en & we`: write `wd` to the word at `addr` at the clock edge; `stall`=0; stay in IDLE. Back-to-back stores every cycle are legal.
  - `en & ~we`: capture the word index, start the array read, load counter with READ_LATENCY-1, and assert `stall`=1 combinationally in the same cycle.
    - Next state is DONE if READ_LATENCY=1, else WAIT.
  - `en`=0: `stall`=0; no action.
- WAIT:
  - `stall`=1; decrement the counter each cycle; go to DONE when the counter reaches 1.
  - If `en` drops while in WAIT, the request is abandoned: return to IDLE and leave `rd` unchanged.
- DONE:
  - `stall`=0; `rd` carries the loaded word.
  - Always return to IDLE next cycle. A request held on `en` in the following cycle is treated as a new request.
- `rd` is registered and holds the last completed load value until the next load completes.
- The array is write-first with respect to its own port. A store followed by a load to the same word returns the new data.
- Stores never stall.

## Timing
- Load accepted in cycle T: `stall`=1 in cycles T..T+READ_LATENCY-1.
- In cycle T+READ_LATENCY: `stall`=0, `rd` is valid, and the master samples `rd` at the end of that cycle.
- Store in cycle T: a load issued in cycle T+1 to the same word returns the stored value.
- Reset values: FSM=IDLE, counter=0, `rd`=0, `err`=0. `stall` is 0 whenever `nrst`=0 and otherwise follows the FSM rules above.
- Array contents are not reset.
- Reset asserted mid-load: return to IDLE immediately, `stall` deasserts, no data is delivered, `rd`=0.

## Configuration
- Macro: `DMEM_RANGE_CHECK_EN`.
- Defined:
  - An access with addr[31:ADDR_W+2] ≠ 0 is out of range.
  - Out-of-range stores are dropped.
  - Out-of-range loads follow the normal latency and return 0.
  - `err` is set in the acceptance cycle's next edge and stays set until reset.
- Undefined:
  - Upper address bits are ignored and addresses alias modulo the depth.
  - `err` is tied to 0.

## Structure
- `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, WAIT, DONE};
  - `DMEM_WORD_W`=32;
  - counter width constant `DMEM_CNT_W`=4.
- Sub-module `dmem_bram_array`:
  - single-port, synchronous read, write-first;
  - parameter `ADDR_W`;
  - written so that tools infer BRAM.
- `dmem_responder` holds the FSM, counter, `rd` register and range check, and connects through a `DataMemory.slave` modport wrapper at the top level.

## Test plan
- Reset with `nrst` low for 3 cycles -> `stall`=0, `rd`=0x00000000, `err`=0.
- Store 0xDEADBEEF to 0x40, then load 0x40 next cycle with READ_LATENCY=2 -> `stall` high for 2 cycles, `rd`=0xDEADBEEF in the 3rd cycle.
- Store 0x11111111 to 0x40 and 0x22222222 to 0x44 on consecutive cycles, then load 0x43 -> returns 0x11111111, since bits [1:0] are ignored.
- READ_LATENCY=1, two back-to-back loads of 0x0 and 0x4 -> `stall` pattern 1,0,1,0 with correct data in each 0 cycle.
- Assert `nrst` low during a load's WAIT cycle -> `stall`=0 immediately, `rd`=0, next load behaves normally.
- Range check with `DMEM_RANGE_CHECK_EN` and ADDR_W=4: store 0x5 to 0x100, then load 0x100 -> returns 0 and `err`=1. Without the macro, the same sequence returns 0x5 from word 0 and `err` stays 0.
